// File: rtl/rp2a03_dma_sched.sv
// rp2a03_dma_sched: bus-cycle sequencer for OAM sprite DMA and DMC sample fetches on the RP2A03 CPU bus.
// Define RP2A03_DMC_DMA_EN to build DMC fetch scheduling; without it only OAM DMA is present.
module rp2a03_dma_sched #(
  parameter logic [15:0] OAM_PORT  = 16'h2004,
  parameter logic [15:0] TRIG_ADDR = 16'h4014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk,
  input  logic [15:0] cpu_a,
  input  logic        cpu_r_nw,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  from_ram,
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic [15:0] dma_a,
  output logic [7:0]  dma_dout,
  output logic        dma_r_nw,
  output logic        dma_active,
  output logic        cpu_ready,
  output logic        dmc_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_DMC_RD,
    S_OAM_RD,
    S_OAM_WR
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       put;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] idx_nxt;
  logic       oam_pend;
  logic       oam_pend_nxt;
  logic       dmc_pend;
  logic       trig;

`ifdef RP2A03_DMC_DMA_EN
  logic dmc_done;

  assign dmc_pend = dmc_req && !dmc_done;
  // The ack coincides with the tick that ends the DMC read, so the APU latches from_ram on the same edge.
  assign dmc_ack  = (state == S_DMC_RD) && cpu_clk;
`else
  logic dmc_unused;

  assign dmc_pend   = 1'b0;
  assign dmc_ack    = 1'b0;
  assign dmc_unused = ^{dmc_req, dmc_addr};
`endif

  // Transfer slot choice on a get cycle: DMC always wins over OAM.
  function automatic state_t serve_state(input logic dmc, input logic oam);
    if (dmc)
      return S_DMC_RD;
    else if (oam)
      return S_OAM_RD;
    else
      return S_IDLE;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_nxt    = state;
    idx_nxt      = idx;
    oam_pend_nxt = oam_pend;
    trig         = (state == S_IDLE) && (cpu_a == TRIG_ADDR) && !cpu_r_nw;

    case (state)
      S_IDLE: begin
        if (oam_pend || dmc_pend)
          state_nxt = S_HALT;
      end
      S_HALT: begin
        // put=1 now means the cycle after this tick is a get cycle.
        if (cpu_r_nw)
          state_nxt = put ? serve_state(dmc_pend, oam_pend) : S_ALIGN;
      end
      S_ALIGN: begin
        state_nxt = serve_state(dmc_pend, oam_pend);
      end
`ifdef RP2A03_DMC_DMA_EN
      S_DMC_RD: begin
        state_nxt = oam_pend ? S_ALIGN : S_IDLE;
      end
`endif
      S_OAM_RD: begin
        state_nxt = S_OAM_WR;
      end
      S_OAM_WR: begin
        idx_nxt = idx + 8'd1;
        if (idx == 8'hFF) begin
          oam_pend_nxt = 1'b0;
          state_nxt    = dmc_pend ? S_DMC_RD : S_IDLE;
        end else begin
          state_nxt = serve_state(dmc_pend, 1'b1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= S_IDLE;
      put        <= 1'b0;
      page       <= 8'h00;
      idx        <= 8'h00;
      oam_pend   <= 1'b0;
      dma_a      <= 16'h0000;
      dma_dout   <= 8'h00;
      dma_r_nw   <= 1'b1;
      dma_active <= 1'b0;
      cpu_ready  <= 1'b1;
    end else if (cpu_clk) begin
      state    <= state_nxt;
      put      <= ~put;
      idx      <= idx_nxt;
      oam_pend <= oam_pend_nxt;

      if (trig) begin
        page     <= cpu_dout;
        oam_pend <= 1'b1;
        idx      <= 8'h00;
      end

      if (state == S_OAM_RD)
        dma_dout <= from_ram;

      // Bus outputs describe the cycle that this tick starts.
      dma_active <= (state_nxt == S_DMC_RD) || (state_nxt == S_OAM_RD) || (state_nxt == S_OAM_WR);
      cpu_ready  <= (state_nxt == S_IDLE);

      case (state_nxt)
        S_DMC_RD: begin
          dma_a    <= dmc_addr;
          dma_r_nw <= 1'b1;
        end
        S_OAM_RD: begin
          dma_a    <= {page, idx_nxt};
          dma_r_nw <= 1'b1;
        end
        S_OAM_WR: begin
          dma_a    <= OAM_PORT;
          dma_r_nw <= 1'b0;
        end
        default: begin
          dma_a    <= 16'h0000;
          dma_r_nw <= 1'b1;
        end
      endcase
    end
  end

`ifdef RP2A03_DMC_DMA_EN
  // Acked requests stay masked until the APU drops dmc_req, checked on every clk.
  always_ff @(posedge clk) begin
    if (rst)
      dmc_done <= 1'b0;
    else if (!dmc_req)
      dmc_done <= 1'b0;
    else if (cpu_clk && (state == S_DMC_RD))
      dmc_done <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_rp2a03_dma_sched.sv
// tb_rp2a03_dma_sched: directed bench for OAM DMA, HALT stalling, reset abort and DMC fetch scheduling.
module tb_rp2a03_dma_sched;

  localparam logic [15:0] OAM_PORT  = 16'h2004;
  localparam logic [15:0] TRIG_ADDR = 16'h4014;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        cpu_clk  = 1'b0;
  logic [15:0] cpu_a    = 16'h0300;
  logic        cpu_r_nw = 1'b1;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  from_ram;
  logic        dmc_req  = 1'b0;
  logic [15:0] dmc_addr = 16'h0000;
  logic [15:0] dma_a;
  logic [7:0]  dma_dout;
  logic        dma_r_nw;
  logic        dma_active;
  logic        cpu_ready;
  logic        dmc_ack;

  int          total = 0;
  int          bad   = 0;
  int          ack_cnt = 0;
  logic [15:0] ack_addr = 16'h0000;
  logic [7:0]  ack_data = 8'h00;

  typedef struct {
    logic        act;
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  dout;
    logic        chk;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];

  rp2a03_dma_sched #(.OAM_PORT(OAM_PORT), .TRIG_ADDR(TRIG_ADDR)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_clk    (cpu_clk),
    .cpu_a      (cpu_a),
    .cpu_r_nw   (cpu_r_nw),
    .cpu_dout   (cpu_dout),
    .from_ram   (from_ram),
    .dmc_req    (dmc_req),
    .dmc_addr   (dmc_addr),
    .dma_a      (dma_a),
    .dma_dout   (dma_dout),
    .dma_r_nw   (dma_r_nw),
    .dma_active (dma_active),
    .cpu_ready  (cpu_ready),
    .dmc_ack    (dmc_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd7;
    return lo ^ a[15:8] ^ 8'h3C;
  endfunction

  // External memory: answers DMA reads only.
  always_comb from_ram = (dma_active && dma_r_nw) ? ram_byte(dma_a) : 8'hEE;

  function automatic rec_t mk(input logic act, input logic [15:0] a, input logic rnw,
                              input logic [7:0] dout, input logic chk);
    rec_t r;
    r.act  = act;
    r.a    = a;
    r.rnw  = rnw;
    r.dout = dout;
    r.chk  = chk;
    return r;
  endfunction

  function automatic bit rec_match(input rec_t g, input rec_t e);
    if (g.act !== e.act) return 1'b0;
    if (e.act && ((g.a !== e.a) || (g.rnw !== e.rnw))) return 1'b0;
    if (e.chk && (g.dout !== e.dout)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("act=%b a=%h rnw=%b dout=%h", r.act, r.a, r.rnw, r.dout);
  endfunction

  // One bus cycle: cpu_clk high for one clk, then one clk low. A seen ack makes the APU drop its request.
  task automatic tick();
    bit acked;
    @(negedge clk);
    cpu_clk = 1'b1;
    #1;
    acked = (dmc_ack === 1'b1);
    if (acked) begin
      ack_cnt++;
      ack_addr = dma_a;
      ack_data = from_ram;
    end
    @(negedge clk);
    cpu_clk = 1'b0;
    if (acked) dmc_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    cpu_clk  = 1'b0;
    dmc_req  = 1'b0;
    cpu_a    = 16'h0300;
    cpu_r_nw = 1'b1;
    cpu_dout = 8'h00;
    ack_cnt  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_tick();
    cpu_a    = 16'h0300;
    cpu_r_nw = 1'b1;
    tick();
  endtask

  task automatic trigger(input logic [7:0] pg);
    cpu_a    = TRIG_ADDR;
    cpu_r_nw = 1'b0;
    cpu_dout = pg;
    tick();
    cpu_a    = 16'h0300;
    cpu_r_nw = 1'b1;
  endtask

  // Records one bus cycle per tick until cpu_ready returns. The CPU writes (to $4014) on capture ticks
  // 1..write_ticks; dmc_req is raised right after record raise_at.
  task automatic capture(input int max_ticks, input int write_ticks, input int raise_at,
                         input logic [15:0] raise_addr, output bit timed_out);
    got_q.delete();
    timed_out = 1'b1;
    for (int j = 0; j < max_ticks; j++) begin
      cpu_r_nw = !((j >= 1) && (j <= write_ticks));
      cpu_a    = ((j >= 1) && (j <= write_ticks)) ? TRIG_ADDR : 16'h0300;
      cpu_dout = 8'h77;
      tick();
      if (cpu_ready === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      got_q.push_back(mk(dma_active, dma_a, dma_r_nw, dma_dout, 1'b0));
      if (j == raise_at) begin
        dmc_req  = 1'b1;
        dmc_addr = raise_addr;
      end
    end
    cpu_r_nw = 1'b1;
    cpu_a    = 16'h0300;
  endtask

  // Expected OAM sequence: halt_cyc idle HALT cycles, optional ALIGN, 256 read/write pairs,
  // with a DMC read plus ALIGN inserted before the read of steal_idx.
  task automatic build_exp(input logic [7:0] pg, input int halt_cyc, input bit align,
                           input int steal_idx, input logic [15:0] daddr);
    logic [15:0] ra;
    exp_q.delete();
    repeat (halt_cyc) exp_q.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
    if (align) exp_q.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
    for (int i = 0; i < 256; i++) begin
      ra = {pg, 8'(i)};
      if (i == steal_idx) begin
        exp_q.push_back(mk(1'b1, daddr, 1'b1, 8'h00, 1'b0));
        exp_q.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
      end
      exp_q.push_back(mk(1'b1, ra, 1'b1, 8'h00, 1'b0));
      exp_q.push_back(mk(1'b1, OAM_PORT, 1'b0, ram_byte(ra), 1'b1));
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (dma_a !== 16'h0000) begin bad++; $display("FAIL reset dma_a: got %h expected 0000", dma_a); end
    total++; if (dma_dout !== 8'h00) begin bad++; $display("FAIL reset dma_dout: got %h expected 00", dma_dout); end
    total++; if (dma_r_nw !== 1'b1) begin bad++; $display("FAIL reset dma_r_nw: got %b expected 1", dma_r_nw); end
    total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL reset dma_active: got %b expected 0", dma_active); end
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL reset cpu_ready: got %b expected 1", cpu_ready); end
    total++; if (dmc_ack !== 1'b0) begin bad++; $display("FAIL reset dmc_ack: got %b expected 0", dmc_ack); end
  endtask

  // Trigger with put=0: HALT lands on a get cycle, so one ALIGN is needed (514 ticks).
  task automatic test_oam_aligned();
    bit to;
    do_reset();
    trigger(8'h02);
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL oam514 ready_after_trigger: got %b expected 1", cpu_ready); end
    capture(700, 0, -1, 16'h0000, to);
    build_exp(8'h02, 1, 1'b1, -1, 16'h0000);
    total++; if (to) begin bad++; $display("FAIL oam514 timeout: got busy expected ready within 700 ticks"); end
    total++; if (got_q.size() != 514) begin bad++; $display("FAIL oam514 length: got %0d expected 514", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (!rec_match(got_q[i], exp_q[i])) begin
        bad++; $display("FAIL oam514 cycle %0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  // CPU writes $4014 twice while halted: HALT holds and the writes are not new triggers.
  task automatic test_halt_on_write();
    bit to;
    do_reset();
    idle_tick();
    trigger(8'h11);
    capture(700, 2, -1, 16'h0000, to);
    build_exp(8'h11, 3, 1'b0, -1, 16'h0000);
    total++; if (to) begin bad++; $display("FAIL halt_wr timeout: got busy expected ready within 700 ticks"); end
    total++; if (got_q.size() != 515) begin bad++; $display("FAIL halt_wr length: got %0d expected 515", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (!rec_match(got_q[i], exp_q[i])) begin
        bad++; $display("FAIL halt_wr cycle %0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  // Abort at idx $80, then a fresh trigger with put=1 restarts at idx 0 with no ALIGN (513 ticks).
  task automatic test_reset_mid();
    bit to;
    do_reset();
    idle_tick();
    trigger(8'h03);
    repeat (258) idle_tick();
    total++; if (dma_a !== 16'h0380) begin bad++; $display("FAIL rst_mid pre_addr: got %h expected 0380", dma_a); end
    total++; if (dma_active !== 1'b1) begin bad++; $display("FAIL rst_mid pre_active: got %b expected 1", dma_active); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL rst_mid active: got %b expected 0", dma_active); end
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL rst_mid ready: got %b expected 1", cpu_ready); end
    total++; if (dma_a !== 16'h0000) begin bad++; $display("FAIL rst_mid dma_a: got %h expected 0000", dma_a); end
    rst = 1'b0;
    idle_tick();
    trigger(8'h04);
    capture(700, 0, -1, 16'h0000, to);
    build_exp(8'h04, 1, 1'b0, -1, 16'h0000);
    total++; if (to) begin bad++; $display("FAIL oam513 timeout: got busy expected ready within 700 ticks"); end
    total++; if (got_q.size() != 513) begin bad++; $display("FAIL oam513 length: got %0d expected 513", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (!rec_match(got_q[i], exp_q[i])) begin
        bad++; $display("FAIL oam513 cycle %0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  // Immediately after the previous DMA (idx wrapped to 0), trigger on put=0 again: 514 ticks.
  task automatic test_back_to_back();
    bit to;
    trigger(8'h05);
    capture(700, 0, -1, 16'h0000, to);
    build_exp(8'h05, 1, 1'b1, -1, 16'h0000);
    total++; if (to) begin bad++; $display("FAIL b2b timeout: got busy expected ready within 700 ticks"); end
    total++; if (got_q.size() != 514) begin bad++; $display("FAIL b2b length: got %0d expected 514", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (!rec_match(got_q[i], exp_q[i])) begin
        bad++; $display("FAIL b2b cycle %0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

`ifdef RP2A03_DMC_DMA_EN
  task automatic test_dmc_idle();
    bit to;
    do_reset();
    dmc_addr = 16'hC123;
    dmc_req  = 1'b1;
    capture(20, 0, -1, 16'h0000, to);
    exp_q.delete();
    exp_q.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
    exp_q.push_back(mk(1'b1, 16'hC123, 1'b1, 8'h00, 1'b0));
    total++; if (to) begin bad++; $display("FAIL dmc_idle timeout: got busy expected ready within 20 ticks"); end
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL dmc_idle length: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (!rec_match(got_q[i], exp_q[i])) begin
        bad++; $display("FAIL dmc_idle cycle %0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i]));
      end
    end
    repeat (3) idle_tick();
    total++; if (ack_cnt != 1) begin bad++; $display("FAIL dmc_idle ack_count: got %0d expected 1", ack_cnt); end
    total++; if (ack_addr !== 16'hC123) begin bad++; $display("FAIL dmc_idle ack_addr: got %h expected c123", ack_addr); end
    total++; if (ack_data !== ram_byte(16'hC123)) begin bad++; $display("FAIL dmc_idle ack_data: got %h expected %h", ack_data, ram_byte(16'hC123)); end
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL dmc_idle ready_after: got %b expected 1", cpu_ready); end
  endtask

  // Request raised during the write of idx $3F: steal, ALIGN, resume at $0640 (513 + 2 ticks).
  task automatic test_dmc_steal();
    bit to;
    do_reset();
    idle_tick();
    trigger(8'h06);
    capture(700, 0, 128, 16'h8F0E, to);
    build_exp(8'h06, 1, 1'b0, 8'h40, 16'h8F0E);
    total++; if (to) begin bad++; $display("FAIL dmc_steal timeout: got busy expected ready within 700 ticks"); end
    total++; if (got_q.size() != 515) begin bad++; $display("FAIL dmc_steal length: got %0d expected 515", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (!rec_match(got_q[i], exp_q[i])) begin
        bad++; $display("FAIL dmc_steal cycle %0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i]));
      end
    end
    total++; if (ack_cnt != 1) begin bad++; $display("FAIL dmc_steal ack_count: got %0d expected 1", ack_cnt); end
    total++; if (ack_addr !== 16'h8F0E) begin bad++; $display("FAIL dmc_steal ack_addr: got %h expected 8f0e", ack_addr); end
  endtask
`else
  task automatic test_dmc_ignored();
    bit to;
    do_reset();
    dmc_addr = 16'hC123;
    dmc_req  = 1'b1;
    idle_tick();
    idle_tick();
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL dmc_off ready: got %b expected 1", cpu_ready); end
    trigger(8'h07);
    capture(700, 0, -1, 16'h0000, to);
    build_exp(8'h07, 1, 1'b1, -1, 16'h0000);
    total++; if (to) begin bad++; $display("FAIL dmc_off timeout: got busy expected ready within 700 ticks"); end
    total++; if (got_q.size() != 514) begin bad++; $display("FAIL dmc_off length: got %0d expected 514", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (!rec_match(got_q[i], exp_q[i])) begin
        bad++; $display("FAIL dmc_off cycle %0d: got %s expected %s", i, fmt(got_q[i]), fmt(exp_q[i]));
      end
    end
    total++; if (ack_cnt != 0) begin bad++; $display("FAIL dmc_off ack_count: got %0d expected 0", ack_cnt); end
    dmc_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_oam_aligned();
    test_halt_on_write();
    test_reset_mid();
    test_back_to_back();
`ifdef RP2A03_DMC_DMA_EN
    test_dmc_idle();
    test_dmc_steal();
`else
    test_dmc_ignored();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rp2a03_dma_sched.md
# rp2a03_dma_sched

CPU-bus DMA scheduler for the RP2A03 core. It owns the bus-cycle sequencing of OAM sprite DMA (page copy to $2004) and DMC sample fetches. It halts the T65 through RDY and aligns transfers to the get/put cycle parity. It arbitrates between the two DMA requesters and drives the DMA side of the top-level address, data and R/W mux.

## Interface
Parameters:
- `OAM_PORT`, 16'h2004, destination address for OAM DMA writes.
- `TRIG_ADDR`, 16'h4014, CPU write address that starts OAM DMA.

Ports:
- `clk` in 1: system clock. This block has one clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_clk` in 1: one-`clk` enable pulse marking each CPU bus-cycle boundary ("tick").
- `cpu_a` in 16: CPU address.
- `cpu_r_nw` in 1: CPU read/write (write low).
- `cpu_dout` in 8: CPU write data.
- `from_ram` in 8: external read data bus.
- `dmc_req` in 1: DMC fetch request, level. The APU holds it until `dmc_ack`.
- `dmc_addr` in 16: DMC fetch address, stable while `dmc_req` is high.
- `dma_a` out 16: DMA address.
- `dma_dout` out 8: DMA write data.
- `dma_r_nw` out 1: DMA read/write.
- `dma_active` out 1: DMA owns the bus this bus cycle. The top level muxes `dma_*` onto the bus when this is high.
- `cpu_ready` out 1: RDY to T65.
- `dmc_ack` out 1: one-`clk` pulse. `from_ram` holds DMC data on this `clk`.

## Operation
- All state advances only on `clk` edges where `cpu_clk`=1 ("ticks"). Outputs are registered and hold for the whole bus cycle that follows the tick.
- Parity bit `put` toggles every tick. It is 0 after reset. get = `put`==0.
- OAM trigger: on a tick with `cpu_a`==`TRIG_ADDR`, `cpu_r_nw`=0 and state IDLE, latch `page`=`cpu_dout`, set `oam_pend`, and clear `idx`. The trigger is ignored in any state other than IDLE.
- DMC pending = `dmc_req` high and not yet acked.
- States:
  - IDLE: `cpu_ready`=1. Go to HALT when any request is pending. `cpu_ready` drops on the same tick.
  - HALT: wait for a tick with `cpu_r_nw`=1, because the CPU only stalls on reads. Stay in HALT while the CPU writes. On exit: if the next cycle is get, go to SERVE; otherwise go to ALIGN.
  - ALIGN: one put cycle with the bus idle, then SERVE.
  - SERVE, get cycle: DMC pending goes to DMC_RD. Otherwise `oam_pend` goes to OAM_RD. DMC has priority.
  - DMC_RD: `dma_a`=`dmc_addr`, `dma_r_nw`=1. At the ending tick, pulse `dmc_ack` and clear DMC pending. If `oam_pend`, go to ALIGN. Otherwise go to IDLE.
  - OAM_RD: `dma_a`={`page`,`idx`}, `dma_r_nw`=1. At the ending tick, latch `dma_dout`=`from_ram` and go to OAM_WR.
  - OAM_WR: `dma_a`=`OAM_PORT`, `dma_r_nw`=0. At the ending tick, `idx`=`idx`+1, which is 8-bit and wraps.
    - If `idx` was 255: clear `oam_pend`, then go to SERVE if DMC is pending, else IDLE.
    - Otherwise go to SERVE. A DMC request raised mid-OAM steals the next get cycle, then one ALIGN, then OAM resumes at the same `idx`.
- `dma_active`=1 only in DMC_RD, OAM_RD and OAM_WR. `cpu_ready` is 0 in every state except IDLE. It returns to 1 on the tick that enters IDLE.

## Timing
- Reset values: `dma_a`=0, `dma_dout`=0, `dma_r_nw`=1, `dma_active`=0, `cpu_ready`=1, `dmc_ack`=0. State is IDLE, `put`=0, `idx`=0, pendings cleared.
- Reset mid-transfer aborts immediately with the reset values above. A DMC request still high after reset is re-serviced.
- OAM DMA length: 1 HALT tick + 0/1 ALIGN tick + 512 transfer cycles = 513 or 514 ticks when there is no DMC interference. Each DMC steal adds 2 ticks.
- A standalone DMC fetch takes 2 or 3 ticks from HALT entry to IDLE.
- `from_ram` is sampled only at the tick that ends a read cycle.

## Configuration
- `RP2A03_DMC_DMA_EN` defined: DMC scheduling is implemented as described above.
- Not defined: `dmc_req` is ignored, `dmc_ack` is tied to 0, and DMC_RD logic is removed. OAM behaviour is unchanged.

## Test plan
- Write $4014=$02 on a tick with `put`=0 → `cpu_ready` low next tick. There are 256 read/write pairs with `dma_a` $0200,$2004,…,$02FF,$2004. `dma_dout` equals the RAM byte. Total 513 or 514 ticks, then `cpu_ready`=1.
- Trigger while the CPU's next cycle is a write → HALT persists until `cpu_r_nw`=1. No `dma_active` occurs before that.
- `dmc_req` with `dmc_addr`=$C123 while idle → single read of $C123, one `dmc_ack` pulse, `cpu_ready` low for 2 or 3 ticks.
- `dmc_req` raised at `idx`=$40 during OAM DMA → next get cycle reads `dmc_addr`, one ALIGN, then OAM resumes at $xx40. Total length +2 ticks and no byte is skipped.
- `rst` asserted at `idx`=$80 → next `clk` gives `dma_active`=0 and `cpu_ready`=1. A new $4014 write starts again at `idx` 0.
- Build without `RP2A03_DMC_DMA_EN` and hold `dmc_req`=1 → no `dmc_ack` and no DMC_RD cycle. OAM DMA completes in 513 or 514 ticks.
